control_unit: RTL and testbench

Fetch/decode/execute sequencer for the 16-bit accumulator machine. It drives the load strobes of ACC, MAR, IR and PC, the ALU opcode, the main-memory write enable, and the register-source selects. It reads only IR contents and an ACC-zero flag. All datapath registers and main memory are external; this block owns only its state machine, status flags and an instruction counter.

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/ctrl_decode.sv | 83 ++++++++
 rtl/control_unit.sv | 74 +++++++
 tb/tb_control_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit accumulator machine controller:
// sequencer states, opcodes, ALU codes and the control strobe bundle.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_MEMWAIT, S_EXEC, S_STORE, S_HALTED
  } state_e;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_NOP = 4'b0000;

  localparam int OPC_W  = 4;
  localparam int ADDR_LO = 0;

  typedef struct packed {
    logic       mar_write;
    logic       mar_src;
    logic       ir_write;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_write;
    logic       acc_src;
    logic [3:0] alu_op;
    logic       mem_write;
  } ctrl_t;

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational next-state and strobe decode for the sequencer; outputs depend
// on state and opcode only, except pc_load on conditional jumps.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_e     state,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  output ctrl_t      ctrl,
  output state_e     state_nxt,
  output logic       set_illegal,
  output logic       clr_illegal,
  output logic       cnt_inc
);

  always_comb begin
    ctrl        = '0;
    state_nxt   = state;
    set_illegal = 1'b0;
    clr_illegal = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH0;
      S_FETCH0: begin
        ctrl.mar_write = 1'b1;
        state_nxt      = S_FETCH1;
      end
      S_FETCH1: state_nxt = S_FETCH2;
      S_FETCH2: begin
        ctrl.ir_write = 1'b1;
        ctrl.pc_inc   = 1'b1;
        cnt_inc       = 1'b1;
        state_nxt     = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = S_FETCH0;
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl.mar_write = 1'b1;
            ctrl.mar_src   = 1'b1;
            state_nxt      = S_MEMWAIT;
          end
          OP_STORE: begin
            ctrl.mar_write = 1'b1;
            ctrl.mar_src   = 1'b1;
            state_nxt      = S_STORE;
          end
          OP_SHL, OP_SHR: begin
            ctrl.acc_write = 1'b1;
            ctrl.alu_op    = alu_code(opcode);
          end
          OP_JUMP: ctrl.pc_load = 1'b1;
          OP_JZ:   ctrl.pc_load = acc_zero;
          OP_JNZ:  ctrl.pc_load = ~acc_zero;
          OP_HALT: state_nxt = S_HALTED;
          default: begin
            set_illegal = 1'b1;
            state_nxt   = S_HALTED;
          end
        endcase
      end
      S_MEMWAIT: state_nxt = S_EXEC;
      S_EXEC: begin
        ctrl.acc_write = 1'b1;
        // LOAD takes memory data directly; the rest go through the ALU
        if (opcode == OP_LOAD) ctrl.acc_src = 1'b1;
        else                   ctrl.alu_op  = alu_code(opcode);
        state_nxt = S_FETCH0;
      end
      S_STORE: begin
        ctrl.mem_write = 1'b1;
        state_nxt      = S_FETCH0;
      end
      S_HALTED: if (start) begin
        clr_illegal = 1'b1;
        state_nxt   = S_FETCH0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: state register, sticky illegal flag and a
// saturating retired-instruction counter around the ctrl_decode block.
module control_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      ir,
  input  logic             acc_zero,
  output logic             mar_write,
  output logic             mar_src,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_write,
  output logic             acc_src,
  output logic [3:0]       alu_op,
  output logic             mem_write,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e state, state_nxt;
  ctrl_t  ctrl;
  logic   set_illegal, clr_illegal, cnt_inc;
  logic   unused_addr;

  // The address field is consumed by the datapath, not here
  assign unused_addr = ^ir[ADDR_W-1:ADDR_LO];

  ctrl_decode u_dec (
    .state       (state),
    .start       (start),
    .opcode      (ir[ADDR_W +: OPC_W]),
    .acc_zero    (acc_zero),
    .ctrl        (ctrl),
    .state_nxt   (state_nxt),
    .set_illegal (set_illegal),
    .clr_illegal (clr_illegal),
    .cnt_inc     (cnt_inc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (clr_illegal)      illegal <= 1'b0;
      else if (set_illegal) illegal <= 1'b1;
      if (cnt_inc && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign mar_write = ctrl.mar_write;
  assign mar_src   = ctrl.mar_src;
  assign ir_write  = ctrl.ir_write;
  assign pc_inc    = ctrl.pc_inc;
  assign pc_load   = ctrl.pc_load;
  assign acc_write = ctrl.acc_write;
  assign acc_src   = ctrl.acc_src;
  assign alu_op    = ctrl.alu_op;
  assign mem_write = ctrl.mem_write;
  assign halted    = (state == S_HALTED);
  assign busy      = (state != S_IDLE) && (state != S_HALTED);

endmodule

// File: tb/tb_control_unit.sv
// Drives control_unit with a small datapath and memory, and checks each
// instruction against an instruction-level machine model.
module tb_control_unit;

  localparam int CNT_W = 4;

  logic clk = 1'b0, reset_n, start, acc_zero;
  logic [15:0] ir;
  logic mar_write, mar_src, ir_write, pc_inc, pc_load, acc_write, acc_src, mem_write;
  logic busy, halted, illegal;
  logic [3:0] alu_op;
  logic [CNT_W-1:0] instr_count;

  control_unit #(.ADDR_W(12), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir(ir), .acc_zero(acc_zero),
    .mar_write(mar_write), .mar_src(mar_src), .ir_write(ir_write), .pc_inc(pc_inc),
    .pc_load(pc_load), .acc_write(acc_write), .acc_src(acc_src), .alu_op(alu_op),
    .mem_write(mem_write), .busy(busy), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // datapath: ACC, PC, MAR, IR, registered memory read port
  logic [15:0] mem [0:16383];
  logic [15:0] acc, pc, dout;
  logic [13:0] mar;
  logic        pk_we;
  logic [13:0] pk_ia, pk_oa;
  logic [15:0] pk_iw, pk_ov;

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b0100: return a << 1;
      4'b0101: return a >> 1;
      default: return 16'hxxxx;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0; pc <= '0; mar <= '0; ir <= '0; dout <= '0;
    end else begin
      if (mar_write) mar <= mar_src ? {2'b00, ir[11:0]} : pc[13:0];
      dout <= mem[mar];
      if (ir_write) ir <= dout;
      if (pc_load) pc <= {4'h0, ir[11:0]};
      else if (pc_inc) pc <= pc + 16'd1;
      if (acc_write) acc <= acc_src ? dout : alu_f(alu_op, acc, dout);
    end
  end

  always @(posedge clk) begin
    if (pk_we) begin
      mem[pk_oa] <= pk_ov;
      mem[pk_ia] <= pk_iw;
    end
    if (mem_write) mem[mar] <= acc;
  end

  assign acc_zero = (acc == 16'd0);

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] smp();
    return {mar_write, mar_src, ir_write, pc_inc, pc_load, acc_write, acc_src, mem_write};
  endfunction

  function automatic logic fetch0();
    return mar_write & ~mar_src;
  endfunction

  // instruction-level model state
  logic [15:0] m_acc, m_pc;
  int          m_cnt;
  logic [7:0]  tr [0:19];
  logic [3:0]  ta [0:19];
  int          tr_n;

  // Call at the negedge where the DUT shows FETCH0; executes one instruction.
  task automatic run(input logic [15:0] w, input logic [15:0] v0);
    logic [3:0]  op;
    logic [11:0] x;
    logic [15:0] v, e_acc, e_pc;
    int          e_cyc, n, nmw, nbad;
    logic        e_halt, e_ill, e_st;
    op = w[15:12]; x = w[11:0];
    v  = ({2'b00, x} == m_pc[13:0]) ? w : v0;
    pk_we = 1'b1; pk_ia = m_pc[13:0]; pk_iw = w; pk_oa = {2'b00, x}; pk_ov = v0;
    e_acc = m_acc; e_pc = m_pc + 16'd1; e_halt = 1'b0; e_ill = 1'b0; e_st = 1'b0;
    e_cyc = 4;
    case (op)
      4'h0: e_halt = 1'b1;
      4'h1: begin e_acc = v;         e_cyc = 6; end
      4'h2: begin e_st = 1'b1;       e_cyc = 5; end
      4'h3: begin e_acc = m_acc + v; e_cyc = 6; end
      4'h4: begin e_acc = m_acc - v; e_cyc = 6; end
      4'h5: begin e_acc = m_acc & v; e_cyc = 6; end
      4'h6: begin e_acc = m_acc | v; e_cyc = 6; end
      4'h7: begin e_acc = m_acc ^ v; e_cyc = 6; end
      4'h8: e_acc = {m_acc[14:0], 1'b0};
      4'h9: e_acc = {1'b0, m_acc[15:1]};
      4'hA: e_pc = {4'h0, x};
      4'hB: if (m_acc == 0) e_pc = {4'h0, x};
      4'hC: if (m_acc != 0) e_pc = {4'h0, x};
      default: begin e_halt = 1'b1; e_ill = 1'b1; end
    endcase
    m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
    n = 0;
    do begin
      tr[n] = smp(); ta[n] = alu_op;
      @(negedge clk);
      pk_we = 1'b0;
      n++;
      start = 1'($urandom_range(0, 1));
    end while (!(fetch0() || halted) && n < 20);
    start = 1'b0;
    tr_n = n;
    nmw = 0; nbad = 0;
    for (int i = 0; i < n; i++) begin
      if (tr[i][0]) nmw++;
      if (ta[i] != 4'b0000 && !tr[i][2]) nbad++;
      if (tr[i][3] && i != 3) nbad++;
    end
    chk($sformatf("cycles op%0h", op), n, e_cyc);
    chk($sformatf("acc op%0h", op), acc, e_acc);
    chk($sformatf("pc op%0h", op), pc, e_pc);
    chk($sformatf("count op%0h", op), instr_count, m_cnt);
    chk($sformatf("halted op%0h", op), halted, e_halt);
    chk($sformatf("illegal op%0h", op), illegal, e_ill);
    chk($sformatf("mem_write cnt op%0h", op), nmw, e_st);
    chk($sformatf("stray strobes op%0h", op), nbad, 0);
    if (e_st) chk("store data", mem[{2'b00, x}], m_acc);
    m_acc = e_acc; m_pc = e_pc;
  endtask

  task automatic resume();
    start = 1'b1;
    @(negedge clk);
    chk("resume fetch0", fetch0(), 1);
    chk("resume illegal clr", illegal, 0);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pk_we = 1'b0;
    pk_ia = '0; pk_oa = '0; pk_iw = '0; pk_ov = '0;
    m_acc = '0; m_pc = '0; m_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst strobes", smp(), 0);
    chk("rst alu_op", alu_op, 0);
    chk("rst flags", {busy, halted, illegal}, 0);
    chk("rst count", instr_count, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    chk("start fetch0", fetch0(), 1);
    start = 1'b0;

    run(16'h1010, 16'h1234);
    chk("load c0", tr[0], 8'b1000_0000);
    chk("load c1", tr[1], 8'b0000_0000);
    chk("load c2", tr[2], 8'b0011_0000);
    chk("load c3", tr[3], 8'b1100_0000);
    chk("load c4", tr[4], 8'b0000_0000);
    chk("load c5", tr[5], 8'b0000_0110);
    run(16'h1011, 16'd5);
    run(16'h3020, 16'd3);
    chk("add exec alu", ta[5], 4'b0000);
    chk("add exec aw", tr[5][2], 1);
    chk("add result", acc, 16'd8);
    run(16'h1012, 16'hBEEF);
    run(16'h2030, 16'h5555);
    chk("store c5 mw", tr[4][0], 1);
    chk("store mem", mem[14'h030], 16'hBEEF);
    run(16'h1013, 16'h0000);
    run(16'hB100, 16'h0000);
    chk("jz taken pc_load", tr[3][3], 1);
    chk("jz taken pc", pc, 16'h0100);
    run(16'h1014, 16'd7);
    run(16'hB100, 16'h0000);
    chk("jz not taken pc_load", tr[3][3], 0);
    chk("jz not taken pc", pc, 16'h0102);
    run(16'hE000, 16'h0000);
    chk("illegal busy", busy, 0);
    resume();

    for (int k = 0; k < 120; k++) begin
      run(16'($urandom), 16'($urandom));
      if (halted) resume();
    end

    // reset in the middle of EXEC of an ADD
    pk_we = 1'b1; pk_ia = m_pc[13:0]; pk_iw = 16'h3040; pk_oa = 14'h040; pk_ov = 16'd1;
    @(negedge clk);
    pk_we = 1'b0;
    repeat (4) @(negedge clk);
    chk("exec reached", acc_write, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst strobes", smp(), 0);
    chk("midrst alu_op", alu_op, 0);
    chk("midrst count", instr_count, 0);
    chk("midrst flags", {busy, halted, illegal}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post rst idle", {busy, halted, fetch0()}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
